// File: rtl/oled_pkg.sv
// oled_pkg: shared definitions for the SSD1306 power-up sequencer.
//   - oled_state_e : sequencer state encoding
//   - CMD_NUM / init_rom() : fixed SSD1306 init command list
//   - OLED_PAGES / OLED_COLS and the page/column addressing opcodes
//   - clear_byte() : {dc, data} for a position inside one page of the clear pass
// Optional build macro: OLED_CLEAR_EN adds the ST_CLEAR state (GDDRAM blanking).
package oled_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_LOW,
        ST_RST_WAIT,
        ST_SEND,
        ST_DONE
`ifdef OLED_CLEAR_EN
        , ST_CLEAR
`endif
    } oled_state_e;

    localparam int CMD_NUM    = 26;
    localparam int IDX_W      = $clog2(CMD_NUM);
    localparam int OLED_PAGES = 8;
    localparam int OLED_COLS  = 128;

    localparam logic [7:0] OP_PAGE_BASE = 8'hB0;
    localparam logic [7:0] OP_COL_LO    = 8'h00;
    localparam logic [7:0] OP_COL_HI    = 8'h10;

    // Per page: page-select, column-low, column-high, then OLED_COLS data bytes.
    localparam int POS_W    = 8;
    localparam int POS_LAST = 3 + OLED_COLS - 1;

    function automatic logic [7:0] init_rom(input logic [IDX_W-1:0] idx);
        case (idx)
            5'd0:  return 8'hAE;  5'd1:  return 8'h00;  5'd2:  return 8'h10;
            5'd3:  return 8'h40;  5'd4:  return 8'h81;  5'd5:  return 8'hCF;
            5'd6:  return 8'hA1;  5'd7:  return 8'hC8;  5'd8:  return 8'hA6;
            5'd9:  return 8'hA8;  5'd10: return 8'h3F;  5'd11: return 8'hD3;
            5'd12: return 8'h00;  5'd13: return 8'hD5;  5'd14: return 8'h80;
            5'd15: return 8'hD9;  5'd16: return 8'hF1;  5'd17: return 8'hDA;
            5'd18: return 8'h12;  5'd19: return 8'hDB;  5'd20: return 8'h40;
            5'd21: return 8'h20;  5'd22: return 8'h02;  5'd23: return 8'h8D;
            5'd24: return 8'h14;  5'd25: return 8'hAF;
            default: return 8'h00;
        endcase
    endfunction

    // Bytes at positions 1..POS_LAST of a page (position 0 is the page select,
    // which depends on the page number and is built by the caller).
    function automatic logic [8:0] clear_byte(input logic [POS_W-1:0] pos);
        if (pos == 8'd1)      return {1'b0, OP_COL_LO};
        else if (pos == 8'd2) return {1'b0, OP_COL_HI};
        else                  return {1'b1, 8'h00};
    endfunction

endpackage

// File: rtl/oled_delay_cnt.sv
// oled_delay_cnt: loadable down-counter used for the reset-low and
// reset-settle intervals.
//   clk_i, rst_ni : clock, async active-low reset
//   load_i        : start a new interval (takes priority over counting)
//   load_val_i    : interval length minus one
//   done_o        : high during the last cycle of the interval
module oled_delay_cnt #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic         active_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (load_i) begin
            cnt_q    <= load_val_i;
            active_q <= 1'b1;
        end else if (active_q) begin
            if (cnt_q == '0) active_q <= 1'b0;
            else             cnt_q    <= cnt_q - 1'b1;
        end
    end

    // Loading N-1 gives exactly N cycles with the counter active.
    assign done_o = active_q && (cnt_q == '0);

endmodule

// File: rtl/oled_init_ctrl.sv
// oled_init_ctrl: SSD1306 power-up sequencer.
// On start: pulses the panel reset low, waits the settle time, streams the
// init command list over a valid/ready byte interface, then raises init_done.
//   clk, rst_n          : system clock, async active-low reset
//   start               : single-cycle (re)init request, ignored while busy
//   cmd_ready           : byte writer accepts the presented byte
//   cmd_valid/data/dc   : presented byte (dc: 0 command, 1 display data)
//   oled_rst_n          : panel reset pin
//   busy, init_done     : sequence in progress / panel ready
// Optional build macro: OLED_CLEAR_EN appends a GDDRAM clear pass.
module oled_init_ctrl
    import oled_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int RST_LOW_US  = 10,
    parameter int RST_WAIT_US = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [7:0] cmd_data,
    output logic       cmd_dc,
    output logic       oled_rst_n,
    output logic       busy,
    output logic       init_done
);

    // 64-bit math: RST_WAIT_US * CLK_FREQ_HZ overflows 32 bits at defaults.
    localparam longint N_LOW  = longint'(RST_LOW_US)  * longint'(CLK_FREQ_HZ) / 64'd1_000_000;
    localparam longint N_WAIT = longint'(RST_WAIT_US) * longint'(CLK_FREQ_HZ) / 64'd1_000_000;
    localparam longint N_MAX  = (N_LOW > N_WAIT) ? N_LOW : N_WAIT;
    localparam int     CNT_W  = (N_MAX > 1) ? $clog2(N_MAX) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CMD_NUM - 1);

    oled_state_e      state_q;
    logic [IDX_W-1:0] idx_q;
    logic             oled_rst_n_q, cmd_valid_q, cmd_dc_q, busy_q, init_done_q;
    logic [7:0]       cmd_data_q;
`ifdef OLED_CLEAR_EN
    logic [2:0]       page_q;
    logic [POS_W-1:0] pos_q;
`endif

    logic             dly_load, dly_done;
    logic [CNT_W-1:0] dly_val;

    // The delay counter is loaded on the same edge the FSM enters a timed state.
    always_comb begin
        dly_load = 1'b0;
        dly_val  = CNT_W'(N_LOW - 1);
        if ((state_q == ST_IDLE || state_q == ST_DONE) && start) begin
            dly_load = 1'b1;
        end else if (state_q == ST_RST_LOW && dly_done) begin
            dly_load = 1'b1;
            dly_val  = CNT_W'(N_WAIT - 1);
        end
    end

    oled_delay_cnt #(.W(CNT_W)) u_dly (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .load_i     (dly_load),
        .load_val_i (dly_val),
        .done_o     (dly_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            oled_rst_n_q <= 1'b1;
            cmd_valid_q  <= 1'b0;
            cmd_data_q   <= 8'h00;
            cmd_dc_q     <= 1'b0;
            busy_q       <= 1'b0;
            init_done_q  <= 1'b0;
`ifdef OLED_CLEAR_EN
            page_q       <= '0;
            pos_q        <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q      <= ST_RST_LOW;
                        oled_rst_n_q <= 1'b0;
                        busy_q       <= 1'b1;
                        init_done_q  <= 1'b0;
                    end
                end
                ST_RST_LOW: begin
                    if (dly_done) begin
                        state_q      <= ST_RST_WAIT;
                        oled_rst_n_q <= 1'b1;
                    end
                end
                ST_RST_WAIT: begin
                    if (dly_done) begin
                        state_q     <= ST_SEND;
                        idx_q       <= '0;
                        cmd_valid_q <= 1'b1;
                        cmd_data_q  <= init_rom('0);
                        cmd_dc_q    <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (cmd_valid_q && cmd_ready) begin
                        if (idx_q == IDX_LAST) begin
`ifdef OLED_CLEAR_EN
                            state_q    <= ST_CLEAR;
                            page_q     <= '0;
                            pos_q      <= '0;
                            cmd_data_q <= OP_PAGE_BASE;
                            cmd_dc_q   <= 1'b0;
`else
                            state_q     <= ST_DONE;
                            cmd_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            init_done_q <= 1'b1;
`endif
                        end else begin
                            idx_q      <= idx_q + 1'b1;
                            cmd_data_q <= init_rom(idx_q + 1'b1);
                        end
                    end
                end
`ifdef OLED_CLEAR_EN
                ST_CLEAR: begin
                    if (cmd_valid_q && cmd_ready) begin
                        if (pos_q == POS_W'(POS_LAST)) begin
                            if (page_q == 3'(OLED_PAGES - 1)) begin
                                state_q     <= ST_DONE;
                                cmd_valid_q <= 1'b0;
                                cmd_dc_q    <= 1'b0;
                                busy_q      <= 1'b0;
                                init_done_q <= 1'b1;
                            end else begin
                                page_q     <= page_q + 3'd1;
                                pos_q      <= '0;
                                cmd_data_q <= OP_PAGE_BASE | {5'b0, page_q + 3'd1};
                                cmd_dc_q   <= 1'b0;
                            end
                        end else begin
                            pos_q                  <= pos_q + 1'b1;
                            {cmd_dc_q, cmd_data_q} <= clear_byte(pos_q + 1'b1);
                        end
                    end
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign oled_rst_n = oled_rst_n_q;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_data   = cmd_data_q;
    assign cmd_dc     = cmd_dc_q;
    assign busy       = busy_q;
    assign init_done  = init_done_q;

endmodule

// File: tb/tb_oled_init_ctrl.sv
// Bench for oled_init_ctrl at default parameters. The expected byte stream is
// built from the SSD1306 init list (plus the clear pass when OLED_CLEAR_EN is
// defined); a per-cycle monitor checks timing, handshake and byte order.
module tb_oled_init_ctrl;

    localparam int N_LOW  = 500;
    localparam int N_WAIT = 5000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_dc;
    logic       oled_rst_n;
    logic       busy;
    logic       init_done;

    int vectors = 0;
    int errors  = 0;

    logic [7:0] rom [26] = '{8'hAE, 8'h00, 8'h10, 8'h40, 8'h81, 8'hCF, 8'hA1,
                             8'hC8, 8'hA6, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'hD5,
                             8'h80, 8'hD9, 8'hF1, 8'hDA, 8'h12, 8'hDB, 8'h40,
                             8'h20, 8'h02, 8'h8D, 8'h14, 8'hAF};
    logic [8:0] exp_q [$];   // {dc, data} in transfer order

    always #10 clk = ~clk;

    oled_init_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cmd_ready  (cmd_ready),
        .cmd_valid  (cmd_valid),
        .cmd_data   (cmd_data),
        .cmd_dc     (cmd_dc),
        .oled_rst_n (oled_rst_n),
        .busy       (busy),
        .init_done  (init_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic build_exp();
        exp_q.delete();
        foreach (rom[i]) exp_q.push_back({1'b0, rom[i]});
`ifdef OLED_CLEAR_EN
        for (int p = 0; p < 8; p++) begin
            exp_q.push_back({1'b0, 8'hB0 + 8'(p)});
            exp_q.push_back({1'b0, 8'h00});
            exp_q.push_back({1'b0, 8'h10});
            repeat (128) exp_q.push_back({1'b1, 8'h00});
        end
`endif
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_oled_rst_n"}, oled_rst_n, 1);
        chk({pfx, "_cmd_valid"}, cmd_valid, 0);
        chk({pfx, "_cmd_data"}, cmd_data, 0);
        chk({pfx, "_cmd_dc"}, cmd_dc, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_init_done"}, init_done, 0);
    endtask

    // mode: 0 ready held 1, 1 random ready, 2 ready dropped 5 cycles at byte 3.
    // poke_wait: pulse start in the middle of the settle wait.
    // abort_at: assert rst_n when this byte index is presented (-1: never).
    task automatic run_seq(input int mode, input bit poke_wait, input int abort_at);
        int lo, hi, k, stall, guard;
        logic pend, pdc;
        logic [7:0] pd;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("init_done_after_start", init_done, 0);
        lo = 0; guard = 0;
        while (oled_rst_n === 1'b0 && guard < 20000) begin
            cmd_ready = 1'($urandom_range(0, 1));
            lo++; guard++;
            @(negedge clk);
        end
        chk("rst_low_cycles", lo, N_LOW);
        hi = 0; guard = 0;
        while (cmd_valid !== 1'b1 && oled_rst_n === 1'b1 && guard < 20000) begin
            start = poke_wait && (hi == 2000);
            cmd_ready = 1'($urandom_range(0, 1));
            hi++; guard++;
            @(negedge clk);
        end
        start = 1'b0;
        chk("rst_wait_cycles", hi, N_WAIT);
        chk("busy_in_send", busy, 1);
        k = 0; pend = 1'b0; stall = 0; guard = 0; pd = '0; pdc = 1'b0;
        while (k < exp_q.size() && guard < 20000) begin
            if (pend) begin
                chk("hold_valid", cmd_valid, 1);
                chk("hold_byte", {cmd_dc, cmd_data}, {pdc, pd});
            end
            if (abort_at >= 0 && k == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk_reset_vals("abort");
                cmd_ready = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            chk("valid_in_stream", cmd_valid, 1);
            case (mode)
                1:       cmd_ready = 1'($urandom_range(0, 1));
                2: begin
                    cmd_ready = !(k == 3 && stall < 5);
                    if (!cmd_ready) stall++;
                end
                default: cmd_ready = 1'b1;
            endcase
            if (cmd_valid && cmd_ready) begin
                chk($sformatf("byte%0d", k), {cmd_dc, cmd_data}, exp_q[k]);
                k++;
                pend = 1'b0;
            end else begin
                pend = 1'b1; pd = cmd_data; pdc = cmd_dc;
            end
            guard++;
            @(negedge clk);
        end
        chk("byte_count", k, exp_q.size());
        if (mode == 2) chk("stall_cycles", stall, 5);
        chk("done_init_done", init_done, 1);
        chk("done_busy", busy, 0);
        chk("done_valid", cmd_valid, 0);
        cmd_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("done_hold_init_done", init_done, 1);
        chk("done_hold_valid", cmd_valid, 0);
    endtask

    initial begin
        build_exp();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        cmd_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_valid", cmd_valid, 0);
        // Full run with ready held high.
        run_seq(0, 1'b0, -1);
        // Re-init from DONE, start poked during the settle wait, stall at byte 3.
        run_seq(2, 1'b1, -1);
        // Reset asserted while byte 10 is presented.
        run_seq(0, 1'b0, 10);
        chk_reset_vals("after_abort");
        // Restart from IDLE with random backpressure.
        run_seq(1, 1'b0, -1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/oled_init_ctrl.md
Name: oled_init_ctrl

Overview:
- Power-up sequencer for the SSD1306 OLED.
- On `start`, it drives the panel reset pulse and waits the settle time.
- It then streams a fixed init command list through a valid/ready byte interface to the serial writer (SPI/I2C), and finally asserts `init_done`.
- Sits between the system clock/reset domain and the OLED byte writer; run-time drawing logic waits on `init_done`.

Parameters:
- CLK_FREQ_HZ, 50_000_000, system clock frequency; one microsecond = CLK_FREQ_HZ/1_000_000 cycles (50 at default).
- RST_LOW_US, 10, duration `oled_rst_n` is held low, in microseconds.
- RST_WAIT_US, 100, delay after reset release before the first command, in microseconds.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle request to (re)run the init sequence
- cmd_ready  input  1  byte writer accepts `cmd_data` this cycle
- cmd_valid  output  1  `cmd_data`/`cmd_dc` valid
- cmd_data  output  8  byte to send
- cmd_dc  output  1  0 = command byte, 1 = display data byte
- oled_rst_n  output  1  panel reset pin, active low
- busy  output  1  sequence in progress
- init_done  output  1  sequence complete; panel ready

Behaviour:
- Reset values (async on `rst_n` low, including mid-operation): state IDLE, `oled_rst_n`=1, `cmd_valid`=0, `cmd_data`=8'h00, `cmd_dc`=0, `busy`=0, `init_done`=0, all counters 0.
- All outputs are registered.
- Fixed cycle counts: N_LOW = RST_LOW_US*CLK_FREQ_HZ/1_000_000 and N_WAIT = RST_WAIT_US*CLK_FREQ_HZ/1_000_000. Delay counter width is $clog2 of the larger value.
- States: IDLE, RST_LOW, RST_WAIT, SEND, DONE.
- IDLE:
  - `start`=1 → RST_LOW next cycle.
  - `busy`=1 from that cycle onward.
- RST_LOW:
  - `oled_rst_n`=0 for exactly N_LOW cycles, then → RST_WAIT.
- RST_WAIT:
  - `oled_rst_n`=1 for exactly N_WAIT cycles, then → SEND.
  - First `cmd_valid`=1 appears on the first SEND cycle.
- SEND:
  - Index idx runs 0..CMD_NUM-1; `cmd_data`=INIT_ROM[idx], `cmd_dc`=0, `cmd_valid`=1.
  - A transfer occurs when `cmd_valid`&&`cmd_ready` are high on a rising edge. Idx then increments and the next byte is presented the following cycle with `cmd_valid` kept high (back-to-back, one byte per cycle when `cmd_ready` is held 1).
  - `cmd_valid` never deasserts and `cmd_data`/`cmd_dc` never change while a byte is pending without `cmd_ready`.
  - Transfer of the last byte → DONE; `cmd_valid`=0 on the next cycle.
- DONE:
  - `init_done`=1, `busy`=0, `cmd_valid`=0.
  - `start` in DONE clears `init_done` and restarts at RST_LOW (re-init).
- `start` while `busy`=1 is ignored.
- `cmd_ready` while `cmd_valid`=0 is ignored.
- Idx never wraps; a sequence always ends in DONE.
- INIT_ROM, CMD_NUM=26: AE 00 10 40 81 CF A1 C8 A6 A8 3F D3 00 D5 80 D9 F1 DA 12 DB 40 20 02 8D 14 AF.

Optional Feature:
- Macro: OLED_CLEAR_EN.
- Defined: after the last init byte, a CLEAR state blanks the GDDRAM.
  - For page p=0..7: commands (B0+p), 00, 10 with `cmd_dc`=0, then 128 bytes 00 with `cmd_dc`=1.
  - That is 1048 transfers under the same handshake rules, then DONE.
- Undefined: no CLEAR state, no page/column counters; SEND → DONE directly.

Decomposition:
- Package oled_pkg:
  - state encoding
  - CMD_NUM
  - INIT_ROM contents as a constant function/array
  - OLED_PAGES=8, OLED_COLS=128
  - command opcodes (page base B0, column low 00, column high 10)
- Sub-module oled_delay_cnt: loadable down-counter with a `done` pulse, reused for RST_LOW and RST_WAIT.

Test Plan:
- Reset: hold `rst_n`=0 → `oled_rst_n`=1, `cmd_valid`=0, `busy`=0, `init_done`=0.
- Full run, `cmd_ready` tied 1, defaults:
  - `start` pulse → `oled_rst_n` low exactly 500 cycles, then high 5000 cycles.
  - Then 26 consecutive valid cycles, first byte AE, last AF, all with `cmd_dc`=0.
  - `init_done`=1 one cycle after the AF transfer.
- Backpressure: drop `cmd_ready` for 5 cycles while idx=3 → `cmd_data` stays 40 and `cmd_valid` stays 1 throughout; no byte skipped or duplicated (scoreboard matches INIT_ROM).
- `start` during RST_WAIT → ignored; timing and byte count unchanged. `start` in DONE → `init_done` falls and the full sequence repeats.
- Assert `rst_n`=0 in SEND at idx=10 → all outputs return to reset values immediately. After release plus `start`, the sequence restarts from AE.
- OLED_CLEAR_EN defined, `cmd_ready`=1: after AF, expect B0 00 10 then 128×00 with `cmd_dc`=1, repeated through page B7. Total 1048 clear transfers, then `init_done`=1.
